// File: rtl/ram_arbiter.sv
// Round-robin arbiter for two masters sharing a single-port synchronous RAM.
// After reset it can zero-fill the RAM before granting any access.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_CLEAR | writing zero to every RAM address, grants held off
// S_RUN   | normal arbitration, one granted access per cycle
module ram_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  or_rvalid0,
    output logic                  or_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  or_ready,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_we,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
    logic                  last_gnt1;

    assign o_rdata = i_ram_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= RST_STATE;
            clr_cnt    <= '0;
            last_gnt1  <= 1'b1;
            or_rvalid0 <= 1'b0;
            or_rvalid1 <= 1'b0;
            or_ready   <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            or_rvalid0 <= o_gnt0 & ~i_we0;
            or_rvalid1 <= o_gnt1 & ~i_we1;
            or_ready   <= (state_nxt == S_RUN);
            if (o_gnt0)
                last_gnt1 <= 1'b0;
            else if (o_gnt1)
                last_gnt1 <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        o_gnt0      = 1'b0;
        o_gnt1      = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_data  = '0;
        case (state)
            S_CLEAR: begin
                o_ram_we    = 1'b1;
                o_ram_addr  = clr_cnt;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (&clr_cnt)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                if (i_rst_n) begin
                    // On a tie the requester not served last wins.
                    if (i_req0 && (!i_req1 || last_gnt1))
                        o_gnt0 = 1'b1;
                    else if (i_req1)
                        o_gnt1 = 1'b1;
                end
                if (o_gnt0) begin
                    o_ram_we   = i_we0;
                    o_ram_addr = i_addr0;
                    o_ram_data = i_data0;
                end else if (o_gnt1) begin
                    o_ram_we   = i_we1;
                    o_ram_addr = i_addr1;
                    o_ram_data = i_data1;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, shadow memory model and a read
// scoreboard checked against the rvalid strobes.
module tb_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        int            who;
        logic [DW-1:0] data;
        int            cyc;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic          gnt0, gnt1, rvalid0, rvalid1, ready;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_we;
    logic          preload;

    logic [DW-1:0] mem     [2**AW];
    logic [DW-1:0] exp_mem [2**AW];
    op_t           ops0[$], ops1[$];
    rd_t           sb[$];
    int            tb_last;
    int            cycle = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_data0(data0), .i_data1(data1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .or_rvalid0(rvalid0), .or_rvalid1(rvalid1),
        .o_rdata(rdata), .or_ready(ready),
        .o_ram_addr(ram_addr), .o_ram_data(ram_wdata), .o_ram_we(ram_we),
        .i_ram_data(ram_rdata)
    );

    // single-port RAM, registered read; preload puts junk in every word
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (preload) begin
            for (int i = 0; i < 2**AW; i++)
                mem[i] <= 8'hA0 | 8'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin : rd_monitor
        rd_t r;
        if (rvalid0 || rvalid1) begin
            check("rv_one_hot", 32'(rvalid0 & rvalid1), 0);
            if (sb.size() == 0) begin
                check("rv_unexpected", 1, 0);
            end else begin
                r = sb.pop_front();
                check("rv_who", 32'(rvalid1), r.who);
                check("rv_cycle", cycle, r.cyc);
                check("rdata", 32'(rdata), 32'(r.data));
            end
        end
    end

    // Drive queued ops; the bench's own round-robin model decides who wins.
    task automatic run_ops();
        int  budget = 0;
        int  e;
        op_t op;
        while ((ops0.size() > 0 || ops1.size() > 0) && budget < 100) begin
            req0 = (ops0.size() > 0);
            req1 = (ops1.size() > 0);
            if (req0) {we0, addr0, data0} = ops0[0];
            if (req1) {we1, addr1, data1} = ops1[0];
            @(negedge clk);
            if (req0 && req1) e = (tb_last == 1) ? 0 : 1;
            else              e = req0 ? 0 : 1;
            check("gnt0", 32'(gnt0), 32'(e == 0));
            check("gnt1", 32'(gnt1), 32'(e == 1));
            op = (e == 0) ? ops0.pop_front() : ops1.pop_front();
            if (op.we) exp_mem[op.addr] = op.data;
            else       sb.push_back('{who: e, data: exp_mem[op.addr], cyc: cycle + 1});
            tb_last = e;
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 100) check("ops_timeout", 1, 0);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Called just after reset release; returns at the negedge where ready is seen.
    task automatic wait_ready(input string tag);
        int e = 0;
        @(negedge clk);
        while (!ready && e < 40) begin
            check("clr_gnt", 32'({gnt0, gnt1}), 0);
            check("clr_addr", 32'(ram_addr), e);
            check("clr_we", 32'(ram_we), 1);
            @(posedge clk);
            #1;
            e++;
            @(negedge clk);
        end
        check({tag, "_edges"}, e, 16);
    endtask

    initial begin
        rst_n = 1'b0; preload = 1'b1; tb_last = 1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        req0 = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(ready), 0);
        check("rst_rvalid", 32'({rvalid0, rvalid1}), 0);
        check("rst_gnt", 32'({gnt0, gnt1}), 0);

        // request held through the clear, granted in the first RUN cycle
        addr0 = 4'd5;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready("clr");
        check("first_run_gnt0", 32'(gnt0), 1);
        sb.push_back('{who: 0, data: 8'd0, cyc: cycle + 1});
        tb_last = 0;
        @(posedge clk);
        #1 req0 = 1'b0;

        for (int i = 0; i < 2**AW; i++) ops0.push_back('{1'b0, AW'(i), 8'd0});
        run_ops();

        ops0.push_back('{1'b1, 4'd3, 8'd11});
        ops0.push_back('{1'b0, 4'd3, 8'd0});
        run_ops();

        for (int i = 0; i < 4; i++) begin
            ops0.push_back('{1'b1, 4'(1 + i), 8'(10 * (i + 1))});
            ops1.push_back('{1'b1, 4'(9 + i), 8'(50 + 10 * i)});
        end
        run_ops();
        for (int i = 0; i < 4; i++) begin
            ops0.push_back('{1'b0, 4'(1 + i), 8'd0});
            ops1.push_back('{1'b0, 4'(9 + i), 8'd0});
        end
        run_ops();

        ops1.push_back('{1'b1, 4'd6, 8'd22});
        run_ops();
        ops0.push_back('{1'b0, 4'd3, 8'd0});
        ops1.push_back('{1'b0, 4'd6, 8'd0});
        run_ops();

        // reset during a read's valid cycle, then reset again mid-clear
        ops0.push_back('{1'b0, 4'd4, 8'd0});
        run_ops();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_rvalid", 32'({rvalid0, rvalid1}), 0);
        check("mid_rst_ready", 32'(ready), 0);
        tb_last = 1;
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready("reclr");
        @(posedge clk);
        #1;

        ops0.push_back('{1'b0, 4'd3, 8'd0});
        ops1.push_back('{1'b0, 4'd6, 8'd0});
        run_ops();

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and power-up clearer for the single-port synchronous RAM (registered read, one-cycle latency). It sits between the RAM and two bus masters (e.g. CPU core and program loader). After reset it zero-fills the whole RAM, then grants one access per cycle and returns read data with a per-requester valid strobe.

## Interface
- ADDR_WIDTH, 8, RAM address width; depth = 2^ADDR_WIDTH
- DATA_WIDTH, 8, RAM word width
- CLEAR_ON_RESET, 1, 1 = zero-fill RAM after reset; 0 = go straight to RUN
- i_clk  in  1  clock, all state changes on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_req0 / i_req1  in  1  access request, requester 0 / 1
- i_we0 / i_we1  in  1  1 = write, 0 = read
- i_addr0 / i_addr1  in  ADDR_WIDTH  access address
- i_data0 / i_data1  in  DATA_WIDTH  write data
- o_gnt0 / o_gnt1  out  1  combinational grant; access executes at the edge closing this cycle
- or_rvalid0 / or_rvalid1  out  1  registered; o_rdata holds this requester's read result this cycle
- o_rdata  out  DATA_WIDTH  read data, direct pass-through of i_ram_data
- or_ready  out  1  registered; 1 once clear has finished (state RUN)
- o_ram_addr  out  ADDR_WIDTH  to RAM i_addr
- o_ram_data  out  DATA_WIDTH  to RAM i_data
- o_ram_we  out  1  to RAM i_we
- i_ram_data  in  DATA_WIDTH  from RAM or_data

## Operation
- States: CLEAR, RUN. Reset state CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR: o_ram_we=1, o_ram_data=0, o_ram_addr=clear counter; counter +1 per cycle; o_gnt0=o_gnt1=0. Requests are ignored but not lost (requester holds). After address 2^ADDR_WIDTH-1 is written -> RUN, counter wraps to 0.
- RUN, no request: o_ram_we=0, o_ram_addr=0, o_ram_data=0, no grants.
- RUN, one request: that requester granted the same cycle.
- RUN, both requesting: grant the requester not served last (last-served pointer, reset value = 1, so requester 0 wins the first tie). Pointer updates only on a grant.
- Granted requester's we/addr/data are muxed onto the RAM port. Exactly one grant per cycle, never both.
- Read grant at cycle N -> or_rvalidX=1 in cycle N+1 only; write grant -> no rvalid.
- Requester contract: hold req/we/addr/data stable until it sees gnt high; drop or change them the cycle after. Holding req after gnt is a new request.
- Reset asserted mid-operation: next edge returns to reset state, clear counter=0, rvalids=0, pointer=1; a clear restarts from address 0.

## Timing
- Reset values: or_ready=0, or_rvalid0=0, or_rvalid1=0, state per CLEAR_ON_RESET; o_gnt0/o_gnt1=0 while in CLEAR or while i_rst_n=0.
- Clear: first edge with i_rst_n=1 writes address 0; edge k writes address k-1; after 2^ADDR_WIDTH edges state=RUN and or_ready=1. With CLEAR_ON_RESET=0, or_ready=1 after the first edge with i_rst_n=1 and grants allowed from that cycle.
- Access latency: write visible to reads granted in the next cycle; read data valid one cycle after grant (o_rdata, or_rvalidX).
- Back-to-back: full throughput, one access per cycle; alternating reads from both requesters produce rvalid0/rvalid1 alternating, each aligned with its own data.
- Fairness: with both continuously requesting, grants strictly alternate; neither waits more than one cycle.

## Test plan
- ADDR_WIDTH=4, DATA_WIDTH=8, CLEAR_ON_RESET=1, preload RAM with non-zero: release reset -> or_ready rises after exactly 16 edges, no grants meanwhile; reads of addresses 0..15 return 8'd0.
- Requester 0 alone: write addr 3 = 8'd11, then read addr 3 -> o_gnt0 same cycle as request, next cycle or_rvalid0=1, o_rdata=8'd11, or_rvalid1=0.
- Both request continuously (req0 writes addr 1..4 = 10,20,30,40; req1 writes addr 9..12 = 50..80) -> grants alternate 0,1,0,1...; read-back of all 8 addresses matches.
- Both read in same cycle (addr 3 -> 8'd11, addr 6 -> 8'd22) -> requester 0 granted first, rvalid0 with 8'd11, then rvalid1 with 8'd22 one cycle later.
- Request asserted during CLEAR -> held ungranted until or_ready=1, then granted in the first RUN cycle.
- Reset pulsed mid-clear (after 5 edges) and mid-read -> rvalids drop to 0, clear restarts at address 0 and takes the full 16 edges.
